// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_ctrl_pkg;

    // Register-file address width.
    localparam int RF_ADDR_W = 5;

    // Register 0 reads as constant zero, so writes to it are discarded.
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

    // Top-level controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester bundle plus register-file write port of rf_write_arbiter.
// master: the side that issues requests and observes the write port.
// slave:  the arbiter itself.
interface rf_write_arbiter_if
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]           req_valid;
    logic [NREQ*RF_ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]     req_data;
    logic [NREQ-1:0]           req_ready;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      we3;
    logic [RF_ADDR_W-1:0]      wa3;
    logic [WIDTH-1:0]          wd3;
    logic [IDX_W-1:0]          grant_id;
    logic                      addr_err;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, we3, wa3, wd3, grant_id, addr_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, we3, wa3, wd3, grant_id, addr_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the
// rotating pointer; the pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    int               idx;

    // Circular search starting at the pointer, wrapping modulo N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IDX_W'(idx);
            end
        end
    end

    assign ptr_next = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // Pointer moves only on an actual accept so idle cycles keep fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port among NREQ requesters
// (round robin, valid/ready) and drives we3/wa3/wd3 from registers.
// Optional clear sweep (zero registers 1..NREGS-1) is built only when
// the macro RF_ARB_CLEAR_EN is defined.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int NREGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]      gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 allow;
    logic                 accept;
    logic [RF_ADDR_W-1:0] addr_arr [NREQ];
    logic [WIDTH-1:0]     data_arr [NREQ];
    logic [RF_ADDR_W-1:0] win_addr;
    logic [WIDTH-1:0]     win_data;
    logic                 win_bad;
    logic                 win_write;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*RF_ADDR_W +: RF_ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grant is withheld during reset and whenever a clear owns the port.
    assign bus.req_ready = allow ? gnt : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    assign win_addr  = addr_arr[gnt_idx];
    assign win_data  = data_arr[gnt_idx];
    assign win_bad   = int'(win_addr) >= NREGS;
    assign win_write = (win_addr != RF_ZERO_ADDR) && !win_bad;

`ifdef RF_ARB_CLEAR_EN
    localparam logic [RF_ADDR_W-1:0] SWEEP_LAST = RF_ADDR_W'(NREGS - 1);

    rf_arb_state_e        state_reg;
    logic [RF_ADDR_W-1:0] sweep_reg;

    // A clear command takes priority over requests in the same cycle.
    assign allow        = !rst && (state_reg == IDLE) && !bus.clr_start;
    assign bus.clr_busy = (state_reg == CLEAR);
`else
    logic unused_clr_start;

    assign allow            = !rst;
    assign bus.clr_busy     = 1'b0;
    assign unused_clr_start = bus.clr_start;
`endif

    // Write-port registers plus the optional clear FSM and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.we3      <= 1'b0;
            bus.wa3      <= '0;
            bus.wd3      <= '0;
            bus.grant_id <= '0;
            bus.addr_err <= 1'b0;
`ifdef RF_ARB_CLEAR_EN
            state_reg    <= IDLE;
            sweep_reg    <= '0;
`endif
        end else begin
            bus.we3      <= 1'b0;
            bus.addr_err <= 1'b0;
            // An accept is only possible in IDLE with no clear command.
            if (accept) begin
                if (win_write) begin
                    bus.we3      <= 1'b1;
                    bus.wa3      <= win_addr;
                    bus.wd3      <= win_data;
                    bus.grant_id <= gnt_idx;
                end
                bus.addr_err <= win_bad;
            end
`ifdef RF_ARB_CLEAR_EN
            case (state_reg)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_reg <= CLEAR;
                        sweep_reg <= RF_ADDR_W'(1);
                        bus.we3   <= 1'b1;
                        bus.wa3   <= RF_ADDR_W'(1);
                        bus.wd3   <= '0;
                    end
                end
                CLEAR: begin
                    // clr_start is ignored here; the sweep never restarts.
                    if (sweep_reg == SWEEP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        sweep_reg <= sweep_reg + 1'b1;
                        bus.we3   <= 1'b1;
                        bus.wa3   <= sweep_reg + 1'b1;
                        bus.wd3   <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
`endif
        end
    end

endmodule
